// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encoding, FSM states, defaults.
package muldiv_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_e;

  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iteration datapath: shift-add multiply, and restoring divide when MULDIV_DIV_EN is defined.
// Outputs are the register values after one more step, so the caller can capture the final step.
module muldiv_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
`ifdef MULDIV_DIV_EN
  input  logic                  i_div,
`endif
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_hi_nxt,
  output logic [DATA_WIDTH-1:0] o_lo_nxt
);

  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH:0]   w_add;

  // Multiply: hi accumulates the partial product, lo shifts the multiplier out / product bits in.
  always_comb begin
    w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  end

`ifdef MULDIV_DIV_EN
  logic                r_div;
  logic [DATA_WIDTH:0] w_shift;
  logic [DATA_WIDTH:0] w_trial;
  logic                w_fits;

  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    w_shift = {r_hi, r_lo[DATA_WIDTH-1]};
    w_trial = w_shift - {1'b0, r_b};
    w_fits  = ~w_trial[DATA_WIDTH];
  end
`endif

  always_comb begin
    o_hi_nxt = w_add[DATA_WIDTH:1];
    o_lo_nxt = {w_add[0], r_lo[DATA_WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (r_div) begin
      o_hi_nxt = w_fits ? w_trial[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
      o_lo_nxt = {r_lo[DATA_WIDTH-2:0], w_fits};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
`ifdef MULDIV_DIV_EN
      r_div <= 1'b0;
`endif
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
`ifdef MULDIV_DIV_EN
      r_div <= i_div;
`endif
    end else if (i_step) begin
      r_hi  <= o_hi_nxt;
      r_lo  <= o_lo_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, sign handling and divide special cases around muldiv_iter.
// Divide ops 4-7 are only implemented when MULDIV_DIV_EN is defined; otherwise they complete with result 0, no write.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [ADDRESS_WIDTH-1:0] wb_addr,
  output logic                     wb_we,
  output logic [1:0]               o_dbg_state
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  state_e                   r_state;
  op_e                      r_op;
  logic                     r_neg;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic [CW-1:0]            r_cnt;
  logic [DATA_WIDTH-1:0]    r_result;
  logic [ADDRESS_WIDTH-1:0] r_wb_addr;
  logic                     r_wr_ok;

  logic                     w_a_sgn;
  logic                     w_b_sgn;
  logic [DATA_WIDTH-1:0]    w_mag_a;
  logic [DATA_WIDTH-1:0]    w_mag_b;
  logic                     w_neg;
  logic                     w_bypass;
  logic [DATA_WIDTH-1:0]    w_bypass_res;
  logic                     w_bypass_we;
  logic                     w_load;
  logic                     w_step;
  logic [DATA_WIDTH-1:0]    w_hi_nxt;
  logic [DATA_WIDTH-1:0]    w_lo_nxt;
  logic [2*DATA_WIDTH-1:0]  w_prod;
  logic [DATA_WIDTH-1:0]    w_final;

  // Remainder follows the dividend's sign; everything else is the XOR of operand signs.
  always_comb begin
    w_a_sgn = a_is_signed(op) & a[DATA_WIDTH-1];
    w_b_sgn = b_is_signed(op) & b[DATA_WIDTH-1];
    w_mag_a = w_a_sgn ? -a : a;
    w_mag_b = w_b_sgn ? -b : b;
    w_neg   = (op[2] && op[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
  end

`ifdef MULDIV_DIV_EN
  logic w_div_zero;
  logic w_ovf;

  always_comb begin
    w_div_zero   = (b == '0);
    w_ovf        = ((op == OP_DIV) || (op == OP_REM)) &&
                   (a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (b == '1);
    w_bypass     = op[2] && (w_div_zero || w_ovf);
    w_bypass_we  = 1'b1;
    if (w_div_zero) w_bypass_res = op[1] ? a : '1;
    else            w_bypass_res = op[1] ? '0 : a;
  end
`else
  always_comb begin
    w_bypass     = op[2];
    w_bypass_we  = 1'b0;
    w_bypass_res = '0;
  end
`endif

  assign w_load = (r_state == IDLE) && start && !w_bypass;
  assign w_step = (r_state == CALC);

  muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
`ifdef MULDIV_DIV_EN
    .i_div    (op[2]),
`endif
    .i_a      (w_mag_a),
    .i_b      (w_mag_b),
    .o_hi_nxt (w_hi_nxt),
    .o_lo_nxt (w_lo_nxt)
  );

  // Sign fix on the value the final step produces, captured as the FSM enters DONE.
  always_comb begin
    w_prod  = {w_hi_nxt, w_lo_nxt};
    if (r_neg) w_prod = -w_prod;
    w_final = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU:              w_final = r_neg ? -w_lo_nxt : w_lo_nxt;
      OP_REM, OP_REMU:              w_final = r_neg ? -w_hi_nxt : w_hi_nxt;
`endif
      default:                      w_final = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= OP_MUL;
      r_neg     <= 1'b0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_wb_addr <= '0;
      r_wr_ok   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op  <= op_e'(op);
            r_rd  <= rd;
            r_neg <= w_neg;
            r_cnt <= '0;
            if (w_bypass) begin
              r_state   <= DONE;
              r_result  <= w_bypass_res;
              r_wb_addr <= rd;
              r_wr_ok   <= w_bypass_we;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_state   <= DONE;
            r_result  <= w_final;
            r_wb_addr <= r_rd;
            r_wr_ok   <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign result      = r_result;
  assign wb_addr     = r_wb_addr;
  assign wb_we       = done && (r_wb_addr != '0) && r_wr_ok;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [AW-1:0] rd;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [AW-1:0] wb_addr;
  logic          wb_we;
  logic [1:0]    dbg_state;

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .rd          (rd),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .wb_addr     (wb_addr),
    .wb_we       (wb_we),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic          exp_we_q[$];
  int            exp_edge_q[$];
  logic [W-1:0]  last_res  = '0;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Result of an op from the RV32M definitions, using 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] res, output logic we_ok, output logic byp);
    logic [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    p  = '0;
    res = '0; we_ok = 1'b1; byp = 1'b0;
    case (o)
      3'd0: begin p = ux * uy; res = p[31:0];  end
      3'd1: begin p = sx * sy; res = p[63:32]; end
      3'd2: begin p = sx * uy; res = p[63:32]; end
      3'd3: begin p = ux * uy; res = p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (y == '0) begin
          byp = 1'b1;
          res = o[1] ? x : '1;
        end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          byp = 1'b1;
          res = o[1] ? '0 : x;
        end else begin
          case (o)
            3'd4:    res = $signed(x) / $signed(y);
            3'd5:    res = x / y;
            3'd6:    res = $signed(x) % $signed(y);
            default: res = x % y;
          endcase
        end
`else
        byp = 1'b1; we_ok = 1'b0; res = '0;
`endif
      end
    endcase
  endfunction

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_busy;
      exp_busy = done || (exp_q.size() > 0);
      chk("busy", busy, exp_busy);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          logic [W-1:0]  er;
          logic [AW-1:0] ea;
          logic          ew;
          int            ee;
          er = exp_q.pop_front();
          ea = exp_addr_q.pop_front();
          ew = exp_we_q.pop_front();
          ee = exp_edge_q.pop_front();
          chk("result", result, er);
          chk("wb_addr", wb_addr, ea);
          chk("wb_we", wb_we, ew);
          chk("done_cycle", edge_cnt, ee);
          last_res  = er;
          last_addr = ea;
        end
      end else begin
        chk("wb_we_idle", wb_we, 1'b0);
        chk("result_hold", result, last_res);
        chk("wb_addr_hold", wb_addr, last_addr);
        if (exp_q.size() > 0 && edge_cnt > exp_edge_q[0]) begin
          chk("done_timeout", done, 1'b1);
          void'(exp_q.pop_front());
          void'(exp_addr_q.pop_front());
          void'(exp_we_q.pop_front());
          void'(exp_edge_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [AW-1:0] r, output logic byp);
    logic [W-1:0] res;
    logic         ok;
    int           guard;
    int           acc;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("issue_wait", busy, 1'b0);
    model(o, x, y, res, ok, byp);
    op = o; a = x; b = y; rd = r; start = 1'b1;
    acc = edge_cnt + 1;
    @(posedge clk);
    #1;
    exp_q.push_back(res);
    exp_addr_q.push_back(r);
    exp_we_q.push_back(ok && (r != '0));
    exp_edge_q.push_back(acc + (byp ? 0 : W));
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
  endtask

  // Re-assert start with other operands while the unit is computing.
  task automatic poke_busy();
    repeat ($urandom_range(2, 20)) @(negedge clk);
    op = 3'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] mr;
    logic         mok, mbyp, byp;
    int           g;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_wb_addr", wb_addr, 5'h0);
    #1 rst = 1'b0;

    // Hand-computed values that pin the model.
    model(3'd0, 32'd7, 32'hFFFF_FFFD, mr, mok, mbyp);
    chk("pin_mul", mr, 32'hFFFF_FFEB);
    model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mr, mok, mbyp);
    chk("pin_mulhu", mr, 32'hFFFF_FFFE);
    model(3'd1, 32'h8000_0000, 32'd2, mr, mok, mbyp);
    chk("pin_mulh", mr, 32'hFFFF_FFFF);
`ifdef MULDIV_DIV_EN
    model(3'd4, 32'hFFFF_FFF9, 32'd2, mr, mok, mbyp);
    chk("pin_div", mr, 32'hFFFF_FFFD);
    model(3'd6, 32'hFFFF_FFF9, 32'd2, mr, mok, mbyp);
    chk("pin_rem", mr, 32'hFFFF_FFFF);
    model(3'd5, 32'd99, 32'd0, mr, mok, mbyp);
    chk("pin_divu0", {mr, 31'b0, mbyp}, {32'hFFFF_FFFF, 32'h1});
    model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, mr, mok, mbyp);
    chk("pin_div_ovf", mr, 32'h8000_0000);
    model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, mr, mok, mbyp);
    chk("pin_rem_ovf", mr, 32'h0);
`else
    model(3'd4, 32'hFFFF_FFF9, 32'd2, mr, mok, mbyp);
    chk("pin_div_off", {mr, 30'b0, mok, mbyp}, {32'h0, 32'h1});
`endif

    // Directed cases run through the DUT.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, byp);
    poke_busy();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, byp);
    issue(3'd1, 32'h8000_0000, 32'd2, 5'd2, byp);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, byp);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, byp);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, byp);
    issue(3'd5, 32'd1234, 32'd0, 5'd6, byp);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, byp);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, byp);
    issue(3'd0, 32'd12345, 32'd678, 5'd0, byp);
    poke_busy();

    // Asynchronous reset mid-calculation.
    issue(3'd0, 32'd7, 32'd3, 5'd9, byp);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_result", result, 32'h0);
    exp_q.delete(); exp_addr_q.delete(); exp_we_q.delete(); exp_edge_q.delete();
    last_res = '0; last_addr = '0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd1, 32'hFFFF_FFF0, 32'd5, 5'd10, byp);

    // Random ops, corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), byp);
      if (!byp && $urandom_range(0, 2) == 0) poke_busy();
    end

    g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which is the operand and result width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 5, which is the destination register address width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request; accepted only in IDLE.
REQ-006 The block SHALL have port op, input, 3 bits: RV32M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-007 The block SHALL have port a, input, DATA_WIDTH: operand rs1, fed from register file read port 1.
REQ-008 The block SHALL have port b, input, DATA_WIDTH: operand rs2, fed from register file read port 2.
REQ-009 The block SHALL have port rd, input, ADDRESS_WIDTH: destination register.
REQ-010 The block SHALL have port busy, output, 1 bit: high while the block holds an operation (state not IDLE).
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse; result valid.
REQ-012 The block SHALL have port result, output, DATA_WIDTH: result for register-file write data.
REQ-013 The block SHALL have port wb_addr, output, ADDRESS_WIDTH: latched rd, for register-file write address.
REQ-014 The block SHALL have port wb_we, output, 1 bit: equals done AND (wb_addr != 0).

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE.
REQ-016 On start in IDLE at edge k, the block SHALL latch op, a, b and rd, and enter CALC at k+1.
REQ-017 CALC SHALL run exactly DATA_WIDTH iteration cycles: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide).
REQ-018 After the last iteration, the FSM SHALL enter DONE, with done=1 at cycle k+DATA_WIDTH+1 (k+33 at the default width), then return to IDLE on the next edge.
REQ-019 Signed operands SHALL be converted to magnitudes before iteration, and the result sign SHALL be applied in DONE entry.
REQ-020 Sign rules: MULHSU treats a as signed and b as unsigned; for REM, the remainder takes the dividend's sign.
REQ-021 The multiply product SHALL be held at full 2*DATA_WIDTH width; MUL returns the low half, MULH/MULHSU/MULHU return the high half.
REQ-022 Divide by zero SHALL bypass CALC and go IDLE->DONE with done at k+1, giving quotient all-ones and remainder = a.
REQ-023 Signed overflow (a = most-negative, b = -1) for DIV/REM SHALL bypass CALC with done at k+1, giving quotient = a and remainder = 0.
REQ-024 start asserted while busy SHALL be ignored, with no effect on latched state or result.
REQ-025 Input changes on a, b, op or rd after acceptance SHALL NOT affect the operation in flight.
REQ-026 result and wb_addr SHALL hold their last value until the next DONE.

Reset
REQ-027 rst SHALL force IDLE asynchronously, including mid-CALC, and discard the operation in flight with no done pulse.
REQ-028 Reset values SHALL be busy=0, done=0, wb_we=0, result=0 and wb_addr=0, with all internal accumulators at 0.

Configuration
REQ-029 When MULDIV_DIV_EN is defined, ops 4-7 SHALL behave as specified above.
REQ-030 When MULDIV_DIV_EN is undefined, ops 4-7 SHALL go IDLE->DONE with done at k+1, result=0 and wb_we=0, and the divider datapath SHALL NOT be synthesised.

Structure
REQ-031 The shared package muldiv_pkg SHALL hold the op encoding enum, the FSM state enum, and a DATA_WIDTH default constant.
REQ-032 The iteration datapath SHALL be one sub-module, muldiv_iter, containing the accumulator/shift registers and the step logic; the FSM, sign fix and special cases SHALL remain in muldiv_unit.

Verification
REQ-033 MUL with a=7, b=-3 and rd=5 SHALL produce done at k+33 with result=0xFFFFFFEB, wb_addr=5 and wb_we=1.
REQ-034 MULHU with a=b=0xFFFFFFFF SHALL produce result=0xFFFFFFFE; MULH with a=0x80000000 and b=2 SHALL produce result=0xFFFFFFFF.
REQ-035 DIV with a=-7 and b=2 SHALL produce result=0xFFFFFFFD; REM with the same operands SHALL produce result=0xFFFFFFFF.
REQ-036 DIVU with b=0 SHALL produce done at k+1 and result=0xFFFFFFFF; DIV with a=0x80000000 and b=-1 SHALL produce result=0x80000000; REM on the same operands SHALL produce 0.
REQ-037 rst asserted at k+10 of a MUL SHALL give busy=0 immediately and no done pulse; a subsequent start SHALL complete normally.
REQ-038 start re-asserted with different operands during CALC SHALL be ignored, the original result SHALL be returned, and rd=0 SHALL give done=1 with wb_we=0.
